// File: rtl/bno085_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bno085_pkg
//  Description : Shared types and constants for the dual-BNO085 SPI path:
//                arbiter state encoding, requester count, the byte-stream
//                handshake bundle and the round-robin owner selection.
//  Revision    : 1.0 - initial release
// ============================================================================
package bno085_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GUARD = 2'd2
  } arb_state_t;

  // Byte-stream handshake a controller presents toward the SPI master.
  typedef struct packed {
    logic       start;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       cs_n;
  } spi_hs_t;

  // Round-robin pick: with both requesting, the one that did not own last wins.
  function automatic logic pick_owner(input logic [NUM_REQ-1:0] req,
                                      input logic               last_owner);
    logic sel;
    if (req[0] && req[1]) begin
      sel = ~last_owner;
    end else if (req[0]) begin
      sel = 1'b0;
    end else begin
      sel = 1'b1;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bno085_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bno085_spi_arbiter
//  Description : Shares one SPI master between two BNO085 controllers.
//                Round-robin grant per transaction, handshake mux/demux,
//                per-sensor chip-select gating, CS-high guard gap and a
//                watchdog that force-releases an overrunning owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module bno085_spi_arbiter
  import bno085_pkg::*;
#(
  parameter int GUARD_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  // requester side
  input  logic [NUM_REQ-1:0]       rq_start,
  input  logic [NUM_REQ-1:0]       rq_tx_valid,
  input  logic [NUM_REQ-1:0][7:0]  rq_tx_data,
  input  logic [NUM_REQ-1:0]       rq_cs_n,
  output logic [NUM_REQ-1:0]       rq_tx_ready,
  output logic [NUM_REQ-1:0]       rq_rx_valid,
  output logic [7:0]               rq_rx_data,
  output logic [NUM_REQ-1:0]       rq_busy,
  // SPI master side
  output logic                     m_start,
  output logic                     m_tx_valid,
  output logic [7:0]               m_tx_data,
  input  logic                     m_tx_ready,
  input  logic                     m_rx_valid,
  input  logic [7:0]               m_rx_data,
  input  logic                     m_busy,
  // sensor pins and status
  output logic [NUM_REQ-1:0]       cs_n_pin,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     timeout_err,
  output logic [NUM_REQ-1:0]       err_sticky
);

  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  arb_state_t           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 first_q, first_d;
  logic                 m_start_q, m_start_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [NUM_REQ-1:0]   err_sticky_q, err_sticky_d;

  logic [NUM_REQ-1:0]   req;
  logic                 timeout_hit;
  spi_hs_t              master_hs;

  // A start pulse counts as a request in the same cycle it arrives so an idle
  // bus reaches m_start two cycles after the pulse.
  assign req         = pend_q | rq_start | ~rq_cs_n;
  assign timeout_hit = (state_q == ARB_GRANT) && (cnt_q == TIMEOUT_LAST);

  // Next-state logic: arbitration, pending starts, shared guard/watchdog counter.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    pend_d        = pend_q | rq_start;
    cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    first_d       = 1'b0;
    m_start_d     = 1'b0;
    timeout_err_d = 1'b0;
    err_sticky_d  = err_sticky_q;

    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          state_d = ARB_GRANT;
          owner_d = pick_owner(req, last_owner_q);
          first_d = 1'b1;
          cnt_d   = '0;
        end
      end

      ARB_GRANT: begin
        // The master start is issued once, on the first granted cycle only.
        if (first_q && pend_q[owner_q]) begin
          m_start_d       = 1'b1;
          pend_d[owner_q] = 1'b0;
        end
        if (timeout_hit) begin
          state_d                = ARB_GUARD;
          timeout_err_d          = 1'b1;
          err_sticky_d[owner_q]  = 1'b1;
          pend_d[owner_q]        = 1'b0;
          last_owner_d           = owner_q;
          cnt_d                  = '0;
        end else if (rq_cs_n[owner_q] && !m_busy && !pend_q[owner_q]) begin
          state_d      = ARB_GUARD;
          last_owner_d = owner_q;
          cnt_d        = '0;
        end
      end

      ARB_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ARB_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      pend_q        <= '0;
      cnt_q         <= '0;
      first_q       <= 1'b0;
      m_start_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      err_sticky_q  <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      pend_q        <= pend_d;
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      m_start_q     <= m_start_d;
      timeout_err_q <= timeout_err_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  // Handshake mux toward the master and demux back to the owner; non-owners
  // see an idle, busy bus and keep their chip select high.
  always_comb begin
    grant       = '0;
    rq_tx_ready = '0;
    rq_rx_valid = '0;
    rq_busy     = '1;
    rq_rx_data  = '0;
    cs_n_pin    = '1;
    master_hs   = '{start: m_start_q, tx_valid: 1'b0, tx_data: 8'h00, cs_n: 1'b1};

    if (state_q == ARB_GRANT) begin
      grant[owner_q]       = 1'b1;
      master_hs.tx_valid   = rq_tx_valid[owner_q];
      master_hs.tx_data    = rq_tx_data[owner_q];
      // Watchdog expiry lifts the pin in the same cycle it fires.
      master_hs.cs_n       = rq_cs_n[owner_q] | timeout_hit;
      rq_tx_ready[owner_q] = m_tx_ready;
      rq_rx_valid[owner_q] = m_rx_valid;
      rq_busy[owner_q]     = m_busy;
      rq_rx_data           = m_rx_data;
      cs_n_pin[owner_q]    = master_hs.cs_n;
    end
  end

  assign m_start     = master_hs.start;
  assign m_tx_valid  = master_hs.tx_valid;
  assign m_tx_data   = master_hs.tx_data;
  assign timeout_err = timeout_err_q;
  assign err_sticky  = err_sticky_q;

endmodule
`default_nettype wire
